// File: rtl/pll_lock_seq_if.sv
// rtl/pll_lock_seq_if.sv - loop-side signal bundle for the PLL acquisition/lock sequencer
interface pll_lock_seq_if;
  logic       fb;
  logic       lockout;
  logic       slew_fast;
  logic       slew_slow;
  logic       freq_load;
  logic [9:0] freq_load_val;
  logic       loop_en;
  logic       locked;
  logic [2:0] state;

  modport master (
    output fb, lockout, slew_fast, slew_slow,
    input  freq_load, freq_load_val, loop_en, locked, state
  );

  modport slave (
    input  fb, lockout, slew_fast, slew_slow,
    output freq_load, freq_load_val, loop_en, locked, state
  );
endinterface

// File: rtl/pll_lock_seq.sv
// rtl/pll_lock_seq.sv - soft-PLL coarse measure, freq preload and lock qualification sequencer
// Optional TRACK timeout/re-measure under `define PLL_LOCK_SEQ_RELOCK_EN.
module pll_lock_seq #(
  parameter int          WIN_LOG2          = 16,
  parameter logic [9:0]  FREQ_MIN_RAW      = 10'd65,
  parameter logic [9:0]  FREQ_MAX_RAW      = 10'd524,
  parameter logic [15:0] LOCK_THRESH       = 16'd256,
  parameter logic [15:0] UNLOCK_THRESH     = 16'd4096,
  parameter int          LOCK_WINDOWS      = 4,
  parameter int          MAX_TRACK_WINDOWS = 64
) (
  input  logic           clk_50,
  input  logic           rst,
  pll_lock_seq_if.slave  bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MEASURE = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_TRACK   = 3'd3;
  localparam logic [2:0] S_LOCKED  = 3'd4;

  localparam int GW = $clog2(LOCK_WINDOWS + 1);
  localparam logic [GW-1:0]       GOOD_ONE    = GW'(1);
  localparam logic [GW-1:0]       GOOD_LAST   = GW'(LOCK_WINDOWS - 1);
  localparam logic [WIN_LOG2-1:0] WIN_ONE     = WIN_LOG2'(1);

  logic [2:0]          state_q, state_d;
  logic [WIN_LOG2-1:0] win_ctr_q, win_ctr_d;
  logic [10:0]         edge_cnt_q, edge_cnt_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [GW-1:0]       good_cnt_q, good_cnt_d;
  logic                fb_d_q;
  logic                freq_load_q, freq_load_d;
  logic [9:0]          freq_load_val_q, freq_load_val_d;
  logic                loop_en_q, loop_en_d;
  logic                locked_q, locked_d;

`ifdef PLL_LOCK_SEQ_RELOCK_EN
  localparam int TW = $clog2(MAX_TRACK_WINDOWS + 1);
  localparam logic [TW-1:0] TRACK_ONE  = TW'(1);
  localparam logic [TW-1:0] TRACK_LAST = TW'(MAX_TRACK_WINDOWS - 1);
  logic [TW-1:0] track_win_q, track_win_d;
`endif

  logic        fb_rise, win_end, slew_act;
  logic [10:0] edge_next;
  logic [15:0] err_next;
  logic [9:0]  clamp_val;

  assign fb_rise   = bus.fb & ~fb_d_q;
  assign win_end   = &win_ctr_q;
  assign slew_act  = bus.slew_fast | bus.slew_slow;
  // Both counts include activity on the window's final cycle.
  assign edge_next = (edge_cnt_q == 11'h7FF) ? edge_cnt_q : edge_cnt_q + {10'd0, fb_rise};
  assign err_next  = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + {15'd0, slew_act};

  always_comb begin
    clamp_val = edge_next[9:0];
    if (edge_next < {1'b0, FREQ_MIN_RAW})
      clamp_val = FREQ_MIN_RAW;
    else if (edge_next > {1'b0, FREQ_MAX_RAW})
      clamp_val = FREQ_MAX_RAW;
  end

  always_comb begin
    state_d         = state_q;
    win_ctr_d       = win_ctr_q + WIN_ONE;
    edge_cnt_d      = edge_cnt_q;
    err_cnt_d       = err_cnt_q;
    good_cnt_d      = good_cnt_q;
    freq_load_d     = 1'b0;
    freq_load_val_d = freq_load_val_q;
    loop_en_d       = loop_en_q;
    locked_d        = locked_q;
`ifdef PLL_LOCK_SEQ_RELOCK_EN
    track_win_d     = track_win_q;
`endif
    case (state_q)
      S_IDLE: begin
        win_ctr_d  = '0;
        edge_cnt_d = '0;
        err_cnt_d  = '0;
        good_cnt_d = '0;
        loop_en_d  = 1'b0;
        locked_d   = 1'b0;
        if (!bus.lockout) state_d = S_MEASURE;
      end
      S_MEASURE: begin
        edge_cnt_d = edge_next;
        if (win_end) begin
          freq_load_val_d = clamp_val;
          freq_load_d     = 1'b1;
          state_d         = S_LOAD;
          win_ctr_d       = '0;
        end
      end
      S_LOAD: begin
        state_d    = S_TRACK;
        loop_en_d  = 1'b1;
        win_ctr_d  = '0;
        err_cnt_d  = '0;
        good_cnt_d = '0;
`ifdef PLL_LOCK_SEQ_RELOCK_EN
        track_win_d = '0;
`endif
      end
      S_TRACK: begin
        err_cnt_d = err_next;
        if (win_end) begin
          err_cnt_d = '0;
          if (err_next <= LOCK_THRESH) begin
            good_cnt_d = good_cnt_q + GOOD_ONE;
            if (good_cnt_q == GOOD_LAST) begin
              state_d    = S_LOCKED;
              locked_d   = 1'b1;
              good_cnt_d = '0;
              win_ctr_d  = '0;
            end
          end else begin
            good_cnt_d = '0;
          end
`ifdef PLL_LOCK_SEQ_RELOCK_EN
          track_win_d = track_win_q + TRACK_ONE;
          // Give up on this preload and re-measure, unless this window just locked.
          if (track_win_q == TRACK_LAST && state_d == S_TRACK) begin
            state_d    = S_MEASURE;
            loop_en_d  = 1'b0;
            edge_cnt_d = '0;
            good_cnt_d = '0;
            win_ctr_d  = '0;
          end
`endif
        end
      end
      S_LOCKED: begin
        err_cnt_d = err_next;
        if (win_end) begin
          err_cnt_d = '0;
          if (err_next >= UNLOCK_THRESH) begin
            state_d    = S_TRACK;
            locked_d   = 1'b0;
            good_cnt_d = '0;
            win_ctr_d  = '0;
`ifdef PLL_LOCK_SEQ_RELOCK_EN
            track_win_d = '0;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Loss of feedback overrides any window-end decision made above.
    if (state_q != S_IDLE && bus.lockout) begin
      state_d         = S_IDLE;
      loop_en_d       = 1'b0;
      locked_d        = 1'b0;
      freq_load_d     = 1'b0;
      freq_load_val_d = freq_load_val_q;
      win_ctr_d       = '0;
    end
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      win_ctr_q       <= '0;
      edge_cnt_q      <= '0;
      err_cnt_q       <= '0;
      good_cnt_q      <= '0;
      fb_d_q          <= 1'b0;
      freq_load_q     <= 1'b0;
      freq_load_val_q <= '0;
      loop_en_q       <= 1'b0;
      locked_q        <= 1'b0;
`ifdef PLL_LOCK_SEQ_RELOCK_EN
      track_win_q     <= '0;
`endif
    end else begin
      state_q         <= state_d;
      win_ctr_q       <= win_ctr_d;
      edge_cnt_q      <= edge_cnt_d;
      err_cnt_q       <= err_cnt_d;
      good_cnt_q      <= good_cnt_d;
      fb_d_q          <= bus.fb;
      freq_load_q     <= freq_load_d;
      freq_load_val_q <= freq_load_val_d;
      loop_en_q       <= loop_en_d;
      locked_q        <= locked_d;
`ifdef PLL_LOCK_SEQ_RELOCK_EN
      track_win_q     <= track_win_d;
`endif
    end
  end

  assign bus.freq_load     = freq_load_q;
  assign bus.freq_load_val = freq_load_val_q;
  assign bus.loop_en       = loop_en_q;
  assign bus.locked        = locked_q;
  assign bus.state         = state_q;
endmodule
